// File: rtl/aeses_uart_seq.sv
// ---------------------------------------------------------------------------
// aeses_uart_seq
//   Byte-level protocol sequencer between a UART and an AES-256 core.
//   Collects KEY_BYTES key bytes and loads the key once. After that it loops:
//   collect BLK_BYTES block bytes, start the core, wait for the result, and
//   stream the BLK_BYTES result bytes back out of the UART transmitter.
//   Byte 0 on the wire is always the most significant byte.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   rx_valid_i    1-cycle strobe, rx_data_i holds a received byte
//   rx_data_i     received byte
//   tx_busy_i     UART transmitter busy
//   tx_start_o    1-cycle strobe, transmit tx_data_o
//   tx_data_o     byte to transmit (held between strobes)
//   key_o         assembled key, byte 0 in the top byte lane
//   key_load_o    1-cycle strobe, core samples key_o
//   blk_o         assembled block, byte 0 in the top byte lane
//   aes_start_o   1-cycle strobe, core starts on blk_o
//   aes_done_i    1-cycle strobe, aes_res_i valid (only honoured in WAIT)
//   aes_res_i     core result
//   state_o       current FSM state, exposed for LEDs and checkers
//   err_o         sticky receive-timeout flag
//
// Handshake: every *_start/*_load/*_done/rx_valid signal is a single-cycle
// strobe with no back-pressure; the only flow control is tx_busy_i, and a new
// tx_start_o is never issued in the cycle right after a previous one so the
// transmitter gets one cycle to raise busy.
// ---------------------------------------------------------------------------
module aeses_uart_seq #(
  parameter int KEY_BYTES  = 32,
  parameter int BLK_BYTES  = 16,
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic [8*KEY_BYTES-1:0] key_o,
  output logic                   key_load_o,
  output logic [8*BLK_BYTES-1:0] blk_o,
  output logic                   aes_start_o,
  input  logic                   aes_done_i,
  input  logic [8*BLK_BYTES-1:0] aes_res_i,
  output logic [2:0]             state_o,
  output logic                   err_o
);

  localparam int CW = $clog2(KEY_BYTES);
  localparam int TW = $clog2(RX_TIMEOUT + 1);

  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLK_BYTES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(RX_TIMEOUT - 1);

  localparam logic [2:0] S_KEY_RX   = 3'd0;
  localparam logic [2:0] S_KEY_LOAD = 3'd1;
  localparam logic [2:0] S_BLK_RX   = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;
  localparam logic [2:0] S_TX_DRAIN = 3'd6;

  logic [2:0]             state_q,     state_d;
  logic [CW-1:0]          cnt_q,       cnt_d;
  logic [TW-1:0]          tmr_q,       tmr_d;
  logic [8*KEY_BYTES-1:0] key_q,       key_d;
  logic [8*BLK_BYTES-1:0] blk_q,       blk_d;
  logic [8*BLK_BYTES-1:0] txsr_q,      txsr_d;
  logic [7:0]             tx_data_q,   tx_data_d;
  logic                   tx_start_q,  tx_start_d;
  logic                   key_load_q,  key_load_d;
  logic                   aes_start_q, aes_start_d;
  logic                   err_q,       err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = '0;
    key_d       = key_q;
    blk_d       = blk_q;
    txsr_d      = txsr_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    key_load_d  = 1'b0;
    aes_start_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_KEY_RX, S_BLK_RX: begin
        if (rx_valid_i) begin
          // Shift in from the LSB end so the first byte ends up on top.
          if (state_q == S_KEY_RX) begin
            key_d = {key_q[8*KEY_BYTES-9:0], rx_data_i};
            if (cnt_q == KEY_LAST) begin
              cnt_d      = '0;
              key_load_d = 1'b1;
              state_d    = S_KEY_LOAD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            blk_d = {blk_q[8*BLK_BYTES-9:0], rx_data_i};
            if (cnt_q == BLK_LAST) begin
              cnt_d   = '0;
              state_d = S_START;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end else if (cnt_q != '0) begin
          // Idle mid-frame: drop the partial frame once the timer expires.
          if (tmr_q == TMR_LAST) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      S_KEY_LOAD: begin
        cnt_d   = '0;
        state_d = S_BLK_RX;
      end
      S_START: begin
        aes_start_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (aes_done_i) begin
          txsr_d  = aes_res_i;
          cnt_d   = '0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        // tx_start_q guard gives the UART one cycle to raise busy.
        if (!tx_busy_i && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = txsr_q[8*BLK_BYTES-1 -: 8];
          txsr_d     = {txsr_q[8*BLK_BYTES-9:0], 8'h00};
          if (cnt_q == BLK_LAST) begin
            cnt_d   = '0;
            state_d = S_TX_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_TX_DRAIN: begin
        // Same guard: busy may not be visible yet right after the last strobe.
        if (!tx_busy_i && !tx_start_q) begin
          state_d = S_BLK_RX;
        end
      end
      default: begin
        state_d = S_KEY_RX;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_KEY_RX;
      cnt_q       <= '0;
      tmr_q       <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      txsr_q      <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      key_load_q  <= 1'b0;
      aes_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      txsr_q      <= txsr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      key_load_q  <= key_load_d;
      aes_start_q <= aes_start_d;
      err_q       <= err_d;
    end
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign key_o       = key_q;
  assign key_load_o  = key_load_q;
  assign blk_o       = blk_q;
  assign aes_start_o = aes_start_q;
  assign state_o     = state_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aeses_uart_seq.sv
module tb_aeses_uart_seq;

  localparam int KB  = 32;
  localparam int BB  = 16;
  localparam int TMO = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid_i = 1'b0;
  logic [7:0]      rx_data_i = 8'h00;
  logic            tx_busy_i;
  logic            tx_start_o;
  logic [7:0]      tx_data_o;
  logic [8*KB-1:0] key_o;
  logic            key_load_o;
  logic [8*BB-1:0] blk_o;
  logic            aes_start_o;
  logic            aes_done_i;
  logic [8*BB-1:0] aes_res_i;
  logic [2:0]      state_o;
  logic            err_o;

  aeses_uart_seq #(.KEY_BYTES(KB), .BLK_BYTES(BB), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_busy_i(tx_busy_i), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .key_o(key_o), .key_load_o(key_load_o),
    .blk_o(blk_o), .aes_start_o(aes_start_o),
    .aes_done_i(aes_done_i), .aes_res_i(aes_res_i),
    .state_o(state_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0]      exp_q[$];      // expected tx bytes
  logic [8*BB-1:0] blk_exp_q[$];  // expected blk_o at each aes_start_o
  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int n_loads  = 0;
  int busy_len = 0;
  logic inject_done = 1'b0;

  typedef struct {
    logic [8*BB-1:0] blk;
    logic [8*BB-1:0] res;
  } vec_t;
  vec_t vec [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- UART transmitter model + tx monitor ----------------
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (key_load_o) n_loads++;
      if (tx_start_o) begin
        n_pulses++;
        check("tx_start_while_busy", 256'(tx_busy_i), 256'(0));
        if (exp_q.size() == 0) begin
          check("tx_unexpected_byte", 256'(tx_data_o), 256'hFFFF_FFFF);
        end else begin
          check("tx_byte", 256'(tx_data_o), 256'(exp_q.pop_front()));
        end
        busy_cnt = busy_len;
      end
      tx_busy_i = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
    end
  end

  // ---------------- AES core model (table lookup, 20-cycle latency) ----------------
  initial begin
    int done_cnt;
    logic [8*BB-1:0] pending;
    done_cnt   = 0;
    pending    = '0;
    aes_done_i = 1'b0;
    aes_res_i  = '0;
    forever begin
      @(negedge clk);
      aes_done_i = 1'b0;
      if (inject_done) begin
        aes_done_i  = 1'b1;
        aes_res_i   = '1;
        inject_done = 1'b0;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          aes_done_i = 1'b1;
          aes_res_i  = pending;
        end
      end
      if (aes_start_o) begin
        if (blk_exp_q.size() == 0) check("aes_start_unexpected", 256'(blk_o), 256'h0);
        else check("blk_o_at_start", 256'(blk_o), 256'(blk_exp_q.pop_front()));
        pending = '0;
        for (int k = 0; k < 5; k++) if (vec[k].blk == blk_o) pending = vec[k].res;
        done_cnt = 20;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d);
    rx_data_i  = d;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic run_block(input logic [8*BB-1:0] blk, input logic [8*BB-1:0] res,
                           input bit chk_lat, input bit stray, input int limit);
    int waited;
    blk_exp_q.push_back(blk);
    for (int b = 0; b < BB; b++) exp_q.push_back(res[8*BB-1-8*b -: 8]);
    for (int b = 0; b < BB; b++) begin
      send_byte(blk[8*BB-1-8*b -: 8]);
      if (b != BB-1) idle($urandom_range(0, 2));
    end
    if (chk_lat) begin
      check("aes_start_not_yet", 256'(aes_start_o), 256'(0));
      check("state_start", 256'(state_o), 256'(3));
      @(negedge clk);
      check("aes_start_2cyc", 256'(aes_start_o), 256'(1));
    end
    if (stray) begin
      @(negedge clk);
      check("state_wait", 256'(state_o), 256'(4));
      send_byte(8'h77);  // must be ignored in WAIT
    end
    waited = 0;
    while (!(exp_q.size() == 0 && state_o == 3'd2) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("block_done_in_time", 256'(waited < limit), 256'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8*KB-1:0] exp_key;
    int p0;
    int waited;

    vec[0] = '{128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
    vec[1] = '{128'h00000000000000000000000000000000, 128'h3c5a0f1e2d4b69788796a5b4c3d2e1f0};
    vec[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdeffedcba9876543210};
    vec[3] = '{128'hdeadbeefcafef00d0badc0de12345678, 128'haa55aa55aa55aa5555aa55aa55aa55aa};
    vec[4] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h13579bdf02468ace13579bdf02468ace};

    // reset state
    rst = 1'b1;
    idle(3);
    check("rst_state", 256'(state_o), 256'(0));
    check("rst_tx_start", 256'(tx_start_o), 256'(0));
    check("rst_tx_data", 256'(tx_data_o), 256'(0));
    check("rst_key", key_o, 256'(0));
    check("rst_key_load", 256'(key_load_o), 256'(0));
    check("rst_blk", 256'(blk_o), 256'(0));
    check("rst_aes_start", 256'(aes_start_o), 256'(0));
    check("rst_err", 256'(err_o), 256'(0));
    rst = 1'b0;
    idle(2);

    // key load 00..1f
    exp_key = '0;
    for (int i = 0; i < KB; i++) begin
      exp_key = {exp_key[8*KB-9:0], 8'(i)};
      send_byte(8'(i));
      if (i != KB-1) begin
        check("no_early_key_load", 256'(key_load_o), 256'(0));
        idle($urandom_range(0, 2));
      end
    end
    check("key_load_1cyc", 256'(key_load_o), 256'(1));
    check("key_value", key_o, exp_key);
    check("state_key_load", 256'(state_o), 256'(1));
    @(negedge clk);
    check("key_load_one_cycle", 256'(key_load_o), 256'(0));
    check("state_blk_rx", 256'(state_o), 256'(2));

    // five blocks, no key resend; stray rx in WAIT and stray done in BLK_RX
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        inject_done = 1'b1;
        idle(2);
        check("done_ignored_blk_rx", 256'(state_o), 256'(2));
      end
      run_block(vec[i].blk, vec[i].res, i == 0, i == 1, 2000);
    end
    check("single_key_load", 256'(n_loads), 256'(1));
    check("key_retained", key_o, exp_key);

    // slow transmitter: busy for 500 cycles after each strobe
    busy_len = 500;
    p0 = n_pulses;
    run_block(vec[3].blk, vec[3].res, 1'b0, 1'b0, 20000);
    check("slow_tx_pulses", 256'(n_pulses - p0), 256'(16));
    busy_len = 3;

    // reset during TX at byte 7
    p0 = n_pulses;
    blk_exp_q.push_back(vec[0].blk);
    for (int b = 0; b < BB; b++) exp_q.push_back(vec[0].res[8*BB-1-8*b -: 8]);
    for (int b = 0; b < BB; b++) send_byte(vec[0].blk[8*BB-1-8*b -: 8]);
    waited = 0;
    while (n_pulses - p0 < 7 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("reach_byte7", 256'(n_pulses - p0), 256'(7));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 256'(state_o), 256'(0));
    check("mid_rst_tx_start", 256'(tx_start_o), 256'(0));
    check("mid_rst_tx_data", 256'(tx_data_o), 256'(0));
    check("mid_rst_key", key_o, 256'(0));
    check("mid_rst_blk", 256'(blk_o), 256'(0));
    check("mid_rst_outs", 256'({key_load_o, aes_start_o, err_o}), 256'(0));
    rst = 1'b0;
    exp_q.delete();
    p0 = n_pulses;
    idle(200);
    check("no_tx_after_rst", 256'(n_pulses - p0), 256'(0));
    check("state_after_rst", 256'(state_o), 256'(0));

    // partial key, timeout, then full key
    for (int i = 0; i < 10; i++) send_byte(8'hc0 + 8'(i));
    idle(TMO - 2);
    check("no_early_timeout", 256'(err_o), 256'(0));
    idle(3);
    check("timeout_err", 256'(err_o), 256'(1));
    check("timeout_state", 256'(state_o), 256'(0));
    p0 = n_loads;
    exp_key = '0;
    for (int i = 0; i < KB; i++) begin
      exp_key = {exp_key[8*KB-9:0], 8'ha0 + 8'(i)};
      send_byte(8'ha0 + 8'(i));
      if (i != KB-1) check("no_load_before_32", 256'(key_load_o), 256'(0));
    end
    check("key_load_after_timeout", 256'(key_load_o), 256'(1));
    check("key_after_timeout", key_o, exp_key);
    check("err_sticky", 256'(err_o), 256'(1));
    @(negedge clk);
    check("one_load_after_timeout", 256'(n_loads - p0), 256'(1));
    run_block(vec[4].blk, vec[4].res, 1'b0, 1'b0, 2000);
    check("scoreboard_empty", 256'(exp_q.size() + blk_exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
